gmii_tx_sched: RTL and testbench

//  Frame-level round-robin scheduler that shares one GMII transmit port among NUM_REQ byte-stream sources.
//  Per frame: preamble (7x 8'h55) + SFD (8'hD5), source payload, then the inter-packet gap.

---
 rtl/gmii_tx_sched.sv | 193 +++++++++++++++++++
 tb/tb_gmii_tx_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_sched.sv
// Round-robin frame scheduler sharing one GMII TX port among NUM_REQ byte-stream sources.
// Each frame is preamble + SFD + payload, followed by an IPG_LEN-cycle idle gap.
module gmii_tx_sched #(
    parameter int NUM_REQ = 2,
    parameter int IPG_LEN = 12,
    parameter int CNT_W   = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_sched_en,
    input  logic [NUM_REQ-1:0]         i_s_valid,
    input  logic [NUM_REQ*8-1:0]       i_s_data,
    input  logic [NUM_REQ-1:0]         i_s_last,
    output logic [NUM_REQ-1:0]         o_s_ready,
    output logic                       o_tx_en,
    output logic [7:0]                 o_txd,
    output logic                       o_tx_er,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic [CNT_W-1:0]           o_frame_cnt,
    output logic [CNT_W-1:0]           o_underrun_cnt
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = (IPG_LEN > 8) ? $clog2(IPG_LEN) : 3;

    // IDLE: wait for grant | PRE: 7x 55 | SFD: D5 | DATA: payload | IPG: inter-packet gap
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_IPG  = 3'd4;

    localparam logic [TW-1:0] PRE_LOAD = TW'(6);
    localparam logic [TW-1:0] IPG_LOAD = TW'(IPG_LEN - 1);

    logic [2:0]       r_state;
    logic [TW-1:0]    r_tmr;
    logic [GW-1:0]    r_ptr;
    logic [GW-1:0]    r_grant;
    logic             r_tx_en;
    logic [7:0]       r_txd;
    logic             r_tx_er;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_underrun_cnt;

    logic             w_req_any;
    logic [GW-1:0]    w_next_gnt;
    logic             w_arb_ok;
    logic             w_gnt_valid;
    logic             w_gnt_last;
    logic [7:0]       w_gnt_data;
    logic             w_hs;
    logic             w_tx_en_nxt;
    logic [7:0]       w_txd_nxt;
    logic             w_tx_er_nxt;

    // Scan downward so the nearest valid source after the pointer is the last one written.
    always_comb begin
        int            v_idx;
        logic [GW-1:0] v_sel;
        w_req_any  = 1'b0;
        w_next_gnt = '0;
        v_idx      = 0;
        v_sel      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            v_sel = GW'(v_idx);
            if (i_s_valid[v_sel]) begin
                w_req_any  = 1'b1;
                w_next_gnt = v_sel;
            end
        end
    end

    assign w_arb_ok    = i_sched_en & w_req_any;
    assign w_gnt_valid = i_s_valid[r_grant];
    assign w_gnt_last  = i_s_last[r_grant];
    assign w_gnt_data  = i_s_data[{r_grant, 3'b000} +: 8];
    assign w_hs        = (r_state == ST_DATA) & w_gnt_valid;

    always_comb begin
        o_s_ready = '0;
        if (r_state == ST_DATA) begin
            o_s_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_tx_en_nxt = 1'b0;
        w_txd_nxt   = 8'h00;
        w_tx_er_nxt = 1'b0;
        case (r_state)
            ST_PRE: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = 8'h55;
            end
            ST_SFD: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = 8'hD5;
            end
            ST_DATA: begin
                w_tx_en_nxt = 1'b1;
                if (w_gnt_valid) begin
                    w_txd_nxt = w_gnt_data;
                end else begin
                    w_tx_er_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_tmr          <= '0;
            r_ptr          <= GW'(NUM_REQ - 1);
            r_grant        <= '0;
            r_tx_en        <= 1'b0;
            r_txd          <= 8'h00;
            r_tx_er        <= 1'b0;
            r_frame_cnt    <= '0;
            r_underrun_cnt <= '0;
        end else begin
            r_tx_en <= w_tx_en_nxt;
            r_txd   <= w_txd_nxt;
            r_tx_er <= w_tx_er_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_ok) begin
                        r_state <= ST_PRE;
                        r_tmr   <= PRE_LOAD;
                        r_grant <= w_next_gnt;
                        r_ptr   <= w_next_gnt;
                    end
                end
                ST_PRE: begin
                    if (r_tmr == '0) begin
                        r_state <= ST_SFD;
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                ST_SFD: begin
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (w_gnt_last) begin
                            r_state     <= ST_IPG;
                            r_tmr       <= IPG_LOAD;
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
                    end
                end
                ST_IPG: begin
                    // The last gap cycle doubles as an arbitration slot for back-to-back frames.
                    if (r_tmr == '0) begin
                        if (w_arb_ok) begin
                            r_state <= ST_PRE;
                            r_tmr   <= PRE_LOAD;
                            r_grant <= w_next_gnt;
                            r_ptr   <= w_next_gnt;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tmr <= r_tmr - TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_en        = r_tx_en;
    assign o_txd          = r_txd;
    assign o_tx_er        = r_tx_er;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_grant_id     = r_grant;
    assign o_frame_cnt    = r_frame_cnt;
    assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Scoreboard bench for gmii_tx_sched: source byte streams feed the DUT while the
// expected GMII byte/error stream and grant order are queued and compared on the output.
module tb_gmii_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int IPG_LEN = 12;
    localparam int CNT_W   = 16;
    localparam int GW      = 2;

    typedef logic [7:0] frame_t [16];
    typedef struct {
        int         src;
        logic [7:0] d;
        bit         last;
        int         stall;
    } sbyte_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sched_en = 1'b1;
    logic [NUM_REQ-1:0]   s_valid = '0;
    logic [NUM_REQ*8-1:0] s_data = '0;
    logic [NUM_REQ-1:0]   s_last = '0;
    logic [NUM_REQ-1:0]   o_s_ready;
    logic                 o_tx_en;
    logic [7:0]           o_txd;
    logic                 o_tx_er;
    logic                 o_busy;
    logic [GW-1:0]        o_grant_id;
    logic [CNT_W-1:0]     o_frame_cnt;
    logic [CNT_W-1:0]     o_underrun_cnt;

    gmii_tx_sched #(.NUM_REQ(NUM_REQ), .IPG_LEN(IPG_LEN), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_sched_en     (sched_en),
        .i_s_valid      (s_valid),
        .i_s_data       (s_data),
        .i_s_last       (s_last),
        .o_s_ready      (o_s_ready),
        .o_tx_en        (o_tx_en),
        .o_txd          (o_txd),
        .o_tx_er        (o_tx_er),
        .o_busy         (o_busy),
        .o_grant_id     (o_grant_id),
        .o_frame_cnt    (o_frame_cnt),
        .o_underrun_cnt (o_underrun_cnt)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    int         gnt_q[$];
    int         gap_q[$];
    sbyte_t     src_q[$];
    int         hold[NUM_REQ];
    int         m_frames = 0;
    int         m_underruns = 0;
    int         m_ptr = NUM_REQ - 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int head_of(input int s);
        for (int i = 0; i < src_q.size(); i++) begin
            if (src_q[i].src == s) return i;
        end
        return -1;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] mask);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (mask[GW'(idx)]) return idx;
        end
        return 0;
    endfunction

    task automatic gen_frame(input int src, input int seed, output frame_t f);
        for (int k = 0; k < 16; k++) begin
            f[k] = 8'(src * 40 + seed * 11 + k * 3 + 1);
        end
    endtask

    task automatic enqueue(input int src, input frame_t f, input int len, input int st_idx, input int st_n);
        for (int k = 0; k < len; k++) begin
            src_q.push_back('{src: src, d: f[k], last: (k == len - 1), stall: (k == st_idx) ? st_n : 0});
        end
    endtask

    task automatic expect_frame(input int src, input frame_t f, input int len, input int st_idx, input int st_n);
        gnt_q.push_back(src);
        for (int k = 0; k < 7; k++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int k = 0; k < len; k++) begin
            if (k == st_idx) begin
                for (int j = 0; j < st_n; j++) exp_q.push_back({1'b1, 8'h00});
                m_underruns += st_n;
            end
            exp_q.push_back({1'b0, f[k]});
        end
        m_frames++;
        m_ptr = src;
    endtask

    task automatic flush_model();
        src_q.delete();
        exp_q.delete();
        gnt_q.delete();
        gap_q.delete();
        for (int s = 0; s < NUM_REQ; s++) hold[s] = 0;
        m_frames    = 0;
        m_underruns = 0;
        m_ptr       = NUM_REQ - 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size() == 0 && !o_busy), 32'd1);
    endtask

    // Source driver: retire handshaken bytes, then present each source's head byte.
    logic [NUM_REQ-1:0] drv_hs;
    int                 drv_h;
    initial begin
        forever begin
            @(negedge clk);
            drv_hs = o_s_ready & s_valid;
            @(posedge clk);
            #1;
            for (int s = 0; s < NUM_REQ; s++) begin
                drv_h = head_of(s);
                if (drv_hs[GW'(s)] && drv_h >= 0) begin
                    src_q.delete(drv_h);
                    drv_h = head_of(s);
                    if (drv_h >= 0) hold[s] = src_q[drv_h].stall;
                end
                if (drv_h < 0) begin
                    s_valid[GW'(s)]              = 1'b0;
                    s_last[GW'(s)]               = 1'b0;
                    s_data[{GW'(s), 3'b000} +: 8] = 8'h00;
                end else begin
                    s_last[GW'(s)]               = src_q[drv_h].last;
                    s_data[{GW'(s), 3'b000} +: 8] = src_q[drv_h].d;
                    if (hold[s] > 0) begin
                        s_valid[GW'(s)] = 1'b0;
                        hold[s]--;
                    end else begin
                        s_valid[GW'(s)] = 1'b1;
                    end
                end
            end
        end
    end

    // Output monitor: scoreboard pop per transmitted cycle, grant check and gap lengths.
    bit mon_prev = 1'b0;
    bit mon_seen = 1'b0;
    int mon_low  = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
                mon_seen = 1'b0;
                mon_low  = 0;
            end else begin
                if (o_tx_en) begin
                    if (!mon_prev) begin
                        if (mon_seen) gap_q.push_back(mon_low);
                        check("grant_pending", 32'(gnt_q.size() != 0), 32'd1);
                        if (gnt_q.size() != 0) check("grant_id", 32'(o_grant_id), 32'(gnt_q.pop_front()));
                    end
                    check("byte_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("txd_er", 32'({o_tx_er, o_txd}), 32'(exp_q.pop_front()));
                    mon_low  = 0;
                    mon_seen = 1'b1;
                end else begin
                    check("idle_txd_er", 32'({o_tx_er, o_txd}), 32'd0);
                    mon_low++;
                end
                mon_prev = o_tx_en;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_t f, f0, f1;
        int     n, lat, p;
        int     cnt[NUM_REQ];
        int     sent[NUM_REQ];
        logic [NUM_REQ-1:0] mask;

        for (int s = 0; s < NUM_REQ; s++) hold[s] = 0;
        repeat (3) @(negedge clk);
        check("rst_tx_en", 32'(o_tx_en), 32'd0);
        check("rst_txd", 32'(o_txd), 32'd0);
        check("rst_tx_er", 32'(o_tx_er), 32'd0);
        check("rst_s_ready", 32'(o_s_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_grant", 32'(o_grant_id), 32'd0);
        check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        check("rst_underrun_cnt", 32'(o_underrun_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single 4-byte frame from source 0
        f = '{default: 8'h00};
        f[0] = 8'hAA; f[1] = 8'hBB; f[2] = 8'hCC; f[3] = 8'hDD;
        enqueue(0, f, 4, -1, 0);
        expect_frame(0, f, 4, -1, 0);
        n = 0;
        while (!s_valid[0] && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        lat = 0;
        while (!o_tx_en && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t1_first_pre_latency", 32'(lat), 32'd2);
        n = 0;
        while (!(o_tx_en && o_txd == 8'hD5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1_s_ready_data", 32'(o_s_ready), 32'b0001);
        check("t1_busy", 32'(o_busy), 32'd1);
        wait_idle("t1_done", 200);
        check("t1_frame_cnt", 32'(o_frame_cnt), 32'(m_frames));
        check("t1_underrun_cnt", 32'(o_underrun_cnt), 32'd0);

        // 2: sources 0 and 1 request together after reset
        do_reset();
        gen_frame(0, 1, f0);
        gen_frame(1, 1, f1);
        enqueue(0, f0, 6, -1, 0);
        enqueue(1, f1, 6, -1, 0);
        mask = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            p = rr_pick(m_ptr, mask);
            expect_frame(p, (p == 0) ? f0 : f1, 6, -1, 0);
            mask[GW'(p)] = 1'b0;
        end
        wait_idle("t2_done", 300);
        check("t2_gap_count", 32'(gap_q.size()), 32'd1);
        if (gap_q.size() != 0) check("t2_gap_len", 32'(gap_q[gap_q.size() - 1]), 32'(IPG_LEN));
        check("t2_frame_cnt", 32'(o_frame_cnt), 32'(m_frames));

        // 3: source 1 underruns for 2 cycles mid-frame
        gen_frame(1, 2, f);
        enqueue(1, f, 6, 2, 2);
        expect_frame(1, f, 6, 2, 2);
        wait_idle("t3_done", 300);
        check("t3_underrun_cnt", 32'(o_underrun_cnt), 32'(m_underruns));
        check("t3_frame_cnt", 32'(o_frame_cnt), 32'(m_frames));

        // 4: reset on the 3rd payload byte, then source 0 wins again
        gen_frame(0, 3, f);
        enqueue(0, f, 8, -1, 0);
        expect_frame(0, f, 8, -1, 0);
        n = 0;
        while (!(o_tx_en && o_txd == f[2]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_byte3", 32'(o_tx_en && o_txd == f[2]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t4_rst_tx_en", 32'(o_tx_en), 32'd0);
        check("t4_rst_txd", 32'(o_txd), 32'd0);
        check("t4_rst_busy", 32'(o_busy), 32'd0);
        check("t4_rst_s_ready", 32'(o_s_ready), 32'd0);
        check("t4_rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        flush_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gen_frame(0, 4, f0);
        gen_frame(1, 4, f1);
        enqueue(0, f0, 3, -1, 0);
        enqueue(1, f1, 3, -1, 0);
        mask = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            p = rr_pick(m_ptr, mask);
            expect_frame(p, (p == 0) ? f0 : f1, 3, -1, 0);
            mask[GW'(p)] = 1'b0;
        end
        wait_idle("t4_done", 300);
        check("t4_frame_cnt", 32'(o_frame_cnt), 32'(m_frames));

        // 5: sched_en dropped during a frame blocks the next grant only
        gen_frame(0, 5, f0);
        gen_frame(0, 6, f1);
        enqueue(0, f0, 5, -1, 0);
        expect_frame(0, f0, 5, -1, 0);
        n = 0;
        while (!o_tx_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        sched_en = 1'b0;
        enqueue(0, f1, 5, -1, 0);
        wait_idle("t5_first_done", 200);
        repeat (30) @(negedge clk);
        check("t5_hold_busy", 32'(o_busy), 32'd0);
        check("t5_hold_tx_en", 32'(o_tx_en), 32'd0);
        check("t5_hold_frame_cnt", 32'(o_frame_cnt), 32'(m_frames));
        expect_frame(0, f1, 5, -1, 0);
        sched_en = 1'b1;
        wait_idle("t5_second_done", 200);
        check("t5_frame_cnt", 32'(o_frame_cnt), 32'(m_frames));

        // 6: all four sources saturated with two frames each
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < NUM_REQ; s++) begin
                gen_frame(s, 10 + r, f);
                enqueue(s, f, 4, -1, 0);
            end
        end
        for (int s = 0; s < NUM_REQ; s++) begin
            cnt[s]  = 2;
            sent[s] = 0;
        end
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            for (int s = 0; s < NUM_REQ; s++) mask[GW'(s)] = (cnt[s] > 0);
            p = rr_pick(m_ptr, mask);
            gen_frame(p, 10 + sent[p], f);
            expect_frame(p, f, 4, -1, 0);
            sent[p]++;
            cnt[p]--;
        end
        wait_idle("t6_done", 2000);
        check("t6_frame_cnt", 32'(o_frame_cnt), 32'd8);
        check("t6_gap_count", 32'(gap_q.size()), 32'd7);
        foreach (gap_q[i]) check("t6_gap_len", 32'(gap_q[i]), 32'(IPG_LEN));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
